// File: rtl/stream2rgb.sv
// Receive end of the packed imager stream: unpacks 32-bit MSB-first words into
// one {r,g,b} pixel per cycle and splits header words into 16-bit meta values.
`ifndef STREAM2RGB_DTYPES
`define STREAM2RGB_DTYPES
`define DTYPE_WIDTH        16
`define DTYPE_FRAME_START  16'h0001
`define DTYPE_FRAME_END    16'h0002
`define DTYPE_HEADER_START 16'h0004
`define DTYPE_HEADER       16'h0008
`define DTYPE_PIXEL_MASK   16'h0F00
`define DTYPE_PIXEL        16'h0100
`define Image_image_type   2
`endif

module stream2rgb #(
    parameter int PIXEL_WIDTH = 10,
    parameter int IBUF_WIDTH  = 64 + 3*PIXEL_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dvi,
    input  logic [`DTYPE_WIDTH-1:0] dtypei,
    input  logic [31:0]             datai,
    output logic                    rdyo,
    output logic                    dvo,
    output logic [`DTYPE_WIDTH-1:0] dtypeo,
    output logic [PIXEL_WIDTH-1:0]  r,
    output logic [PIXEL_WIDTH-1:0]  g,
    output logic [PIXEL_WIDTH-1:0]  b,
    output logic [15:0]             meta_datao,
    output logic [7:0]              meta_idx,
    output logic [15:0]             image_type
);

    localparam int         PW3       = 3*PIXEL_WIDTH;
    localparam logic [6:0] PW3_P     = 7'(PW3);
    localparam logic [6:0] RDY_LIMIT = 7'(32 + PW3);
    localparam logic [7:0] IMG_IDX   = 8'(`Image_image_type);

    logic [IBUF_WIDTH-1:0]   ibuf;
    logic [6:0]              ipos;
    logic [6:0]              ipos_ae;
    logic                    hdr_pend;
    logic [15:0]             hdr_hold;
    logic [7:0]              idx;
    logic [7:0]              idx_inc;
    logic [`DTYPE_WIDTH-1:0] pix_dtype;
    logic                    emit;
    logic                    is_pix;
    logic                    accept;
    logic [PW3-1:0]          pix;

    always_comb begin
        emit    = (ipos >= PW3_P) && !hdr_pend;
        ipos_ae = emit ? (ipos - PW3_P) : ipos;
        is_pix  = |(dtypei & `DTYPE_PIXEL_MASK);
        // Non-pixel words wait until no whole pixel is left in the accumulator.
        if (hdr_pend)
            rdyo = 1'b0;
        else if (is_pix)
            rdyo = (ipos_ae <= RDY_LIMIT);
        else
            rdyo = !emit && (ipos < PW3_P);
        accept  = dvi && rdyo;
        pix     = PW3'(ibuf >> (ipos - PW3_P));
        idx_inc = (idx == 8'hFF) ? idx : idx + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ibuf       <= '0;
            ipos       <= '0;
            hdr_pend   <= 1'b0;
            hdr_hold   <= '0;
            idx        <= '0;
            pix_dtype  <= '0;
            dvo        <= 1'b0;
            dtypeo     <= '0;
            r          <= '0;
            g          <= '0;
            b          <= '0;
            meta_datao <= '0;
            meta_idx   <= '0;
            image_type <= '0;
        end else begin
            dvo <= 1'b0;

            if (emit) begin
                {r, g, b} <= pix;
                dvo       <= 1'b1;
                dtypeo    <= pix_dtype;
            end

            if (hdr_pend) begin
                meta_datao <= hdr_hold;
                meta_idx   <= idx;
                dvo        <= 1'b1;
                dtypeo     <= `DTYPE_HEADER;
                hdr_pend   <= 1'b0;
                idx        <= idx_inc;
                if (idx == IMG_IDX)
                    image_type <= hdr_hold;
            end

            if (accept) begin
                if (is_pix) begin
                    ibuf      <= {ibuf[IBUF_WIDTH-33:0], datai};
                    pix_dtype <= dtypei;
                end else begin
                    dvo    <= 1'b1;
                    dtypeo <= dtypei;
                    if (dtypei == `DTYPE_HEADER) begin
                        // Low half goes out now, high half on the following cycle.
                        meta_datao <= datai[15:0];
                        meta_idx   <= idx;
                        hdr_hold   <= datai[31:16];
                        hdr_pend   <= 1'b1;
                        idx        <= idx_inc;
                        if (idx == IMG_IDX)
                            image_type <= datai[15:0];
                    end else if (dtypei == `DTYPE_FRAME_START || dtypei == `DTYPE_HEADER_START) begin
                        idx <= '0;
                    end
                end
            end

            if (accept && is_pix)
                ipos <= ipos_ae + 7'd32;
            else if (accept)
                ipos <= '0;
            else
                ipos <= ipos_ae;
        end
    end

endmodule

// File: tb/tb_stream2rgb.sv
// Bench for stream2rgb: a bitstream-level model predicts every output event,
// directed sections pin latency, hold-off, header split and reset behaviour.
`timescale 1ns/1ps
`ifndef STREAM2RGB_DTYPES
`define STREAM2RGB_DTYPES
`define DTYPE_WIDTH        16
`define DTYPE_FRAME_START  16'h0001
`define DTYPE_FRAME_END    16'h0002
`define DTYPE_HEADER_START 16'h0004
`define DTYPE_HEADER       16'h0008
`define DTYPE_PIXEL_MASK   16'h0F00
`define DTYPE_PIXEL        16'h0100
`define Image_image_type   2
`endif

module tb_stream2rgb;

    localparam int          PW    = 10;
    localparam int          PW3   = 30;
    localparam logic [15:0] PIX_A = `DTYPE_PIXEL;
    localparam logic [15:0] PIX_B = 16'h0200;

    typedef enum int {K_PIX, K_META, K_CTRL} kind_t;
    typedef struct {
        kind_t       kind;
        logic [15:0] dtype;
        logic [29:0] pix;
        logic [15:0] meta;
        logic [7:0]  idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          dvi = 1'b0;
    logic [15:0]   dtypei = '0;
    logic [31:0]   datai = '0;
    logic          rdyo;
    logic          dvo;
    logic [15:0]   dtypeo;
    logic [PW-1:0] r;
    logic [PW-1:0] g;
    logic [PW-1:0] b;
    logic [15:0]   meta_datao;
    logic [7:0]    meta_idx;
    logic [15:0]   image_type;

    stream2rgb #(.PIXEL_WIDTH(PW)) dut (
        .clk(clk), .reset(reset), .dvi(dvi), .dtypei(dtypei), .datai(datai),
        .rdyo(rdyo), .dvo(dvo), .dtypeo(dtypeo), .r(r), .g(g), .b(b),
        .meta_datao(meta_datao), .meta_idx(meta_idx), .image_type(image_type)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rdyo_low = 0;
    int          m_idx = 0;
    logic [15:0] m_image_type = '0;
    exp_t        expq[$];
    exp_t        cur;
    logic [29:0] obs_pix[$];
    int          pix_cycs[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    // Compare process: every dvo cycle must match the next predicted event.
    initial forever begin
        @(negedge clk);
        if (!reset && dvo) begin
            if (expq.size() == 0) begin
                check("spurious_dvo", dvo, 1'b0);
            end else begin
                cur = expq.pop_front();
                check("dtypeo", dtypeo, cur.dtype);
                if (cur.kind == K_PIX) begin
                    check("pixel_rgb", {r, g, b}, cur.pix);
                    obs_pix.push_back({r, g, b});
                    pix_cycs.push_back(cyc);
                end else if (cur.kind == K_META) begin
                    check("meta_datao", meta_datao, cur.meta);
                    check("meta_idx", meta_idx, cur.idx);
                    if (cur.idx == 8'(`Image_image_type))
                        check("image_type_latch", image_type, cur.meta);
                end
            end
        end
    end

    task automatic exp_ctrl(input logic [15:0] dt);
        exp_t e;
        e.kind = K_CTRL; e.dtype = dt; e.pix = '0; e.meta = '0; e.idx = '0;
        expq.push_back(e);
        if (dt == `DTYPE_FRAME_START || dt == `DTYPE_HEADER_START) m_idx = 0;
    endtask

    task automatic exp_meta(input logic [15:0] v);
        exp_t e;
        e.kind = K_META; e.dtype = `DTYPE_HEADER; e.pix = '0; e.meta = v; e.idx = 8'(m_idx);
        expq.push_back(e);
        if (m_idx == `Image_image_type) m_image_type = v;
        if (m_idx < 255) m_idx++;
    endtask

    task automatic pack_pixels(input logic [29:0] px[$], output logic [31:0] wq[$]);
        bit          bq[$];
        logic [31:0] w;
        wq.delete();
        foreach (px[p]) for (int k = PW3-1; k >= 0; k--) bq.push_back(px[p][k]);
        while (bq.size() % 32 != 0) bq.push_back(1'b0);
        for (int j = 0; j < bq.size(); j += 32) begin
            w = '0;
            for (int k = 0; k < 32; k++) w = {w[30:0], bq[j+k]};
            wq.push_back(w);
        end
    endtask

    // Every complete 30-bit group of the word bitstream becomes a pixel.
    task automatic exp_pixels(input logic [31:0] wq[$], input logic [15:0] dt, output int n);
        bit          bq[$];
        exp_t        e;
        logic [29:0] v;
        n = 0;
        foreach (wq[j]) for (int k = 31; k >= 0; k--) bq.push_back(wq[j][k]);
        for (int p = 0; p + PW3 <= bq.size(); p += PW3) begin
            v = '0;
            for (int k = 0; k < PW3; k++) v = {v[28:0], bq[p+k]};
            e.kind = K_PIX; e.dtype = dt; e.pix = v; e.meta = '0; e.idx = '0;
            expq.push_back(e);
            n++;
        end
    endtask

    task automatic send_word(input logic [15:0] dt, input logic [31:0] d, output int waits);
        logic acc;
        bit   done;
        dvi = 1'b1; dtypei = dt; datai = d;
        waits = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            acc = rdyo;
            if (!acc) rdyo_low++;
            @(posedge clk); #1;
            if (acc) done = 1;
            else begin
                waits++;
                if (waits > 200) begin
                    check("send_timeout", waits, 0);
                    done = 1;
                end
            end
        end
        dvi = 1'b0;
    endtask

    task automatic send_ctrl(input logic [15:0] dt);
        int wt;
        exp_ctrl(dt);
        send_word(dt, 32'h0, wt);
    endtask

    task automatic send_header(input logic [31:0] w);
        int wt;
        exp_meta(w[15:0]);
        exp_meta(w[31:16]);
        send_word(`DTYPE_HEADER, w, wt);
        @(negedge clk);
        check("hdr_second_half_rdyo", rdyo, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic send_words(input logic [31:0] wq[$], input logic [15:0] dt, input bit stall);
        int wt;
        foreach (wq[j]) begin
            if (stall && $urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
            send_word(dt, wq[j], wt);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (expq.size() > 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, expq.size(), 0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_dvo"}, dvo, 1'b0);
        check({tag, "_dtypeo"}, dtypeo, 16'h0);
        check({tag, "_rgb"}, {r, g, b}, 30'h0);
        check({tag, "_meta"}, {meta_datao, meta_idx}, 24'h0);
        check({tag, "_image_type"}, image_type, 16'h0);
        check({tag, "_rdyo"}, rdyo, 1'b1);
        check({tag, "_ipos"}, dut.ipos, 7'd0);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b1; dvi = 1'b0;
        @(posedge clk); #1;
        expq.delete();
        m_idx = 0; m_image_type = '0;
        check_reset_state(tag);
        reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] px16[$];
        logic [29:0] px100[$];
        logic [31:0] wq16[$];
        logic [31:0] wq100[$];
        logic [31:0] wone[$];
        int          wt, n, base, base2, pc0;

        repeat (3) @(posedge clk);
        #1;
        expq.delete();
        check_reset_state("por");
        reset = 1'b0;

        // 16-pixel stream: latency, throughput, order.
        for (int i = 0; i < 16; i++) px16.push_back({10'(i), 10'(i + 16), 10'(i + 32)});
        pack_pixels(px16, wq16);
        check("stream_word_count", wq16.size(), 15);
        send_ctrl(`DTYPE_FRAME_START);
        exp_pixels(wq16, PIX_A, n);
        check("stream_model_count", n, 16);
        base = pix_cycs.size();
        rdyo_low = 0;
        pc0 = cyc;
        send_word(PIX_A, wq16[0], wt);
        check("first_word_wait", wt, 0);
        for (int i = 1; i < 15; i++) send_word(PIX_A, wq16[i], wt);
        send_ctrl(`DTYPE_FRAME_END);
        drain("stream_drain");
        check("stream_pix_count", pix_cycs.size() - base, 16);
        check("latency", pix_cycs[base] - pc0, 2);
        check("throughput", pix_cycs[base + 15] - pix_cycs[base], 15);
        check("pixel0_literal", obs_pix[base], {10'd0, 10'd16, 10'd32});
        check("pixel15_literal", obs_pix[base + 15], {10'd15, 10'd31, 10'd47});
        check("stream_rdyo_low", rdyo_low > 0, 1'b1);
        check("stream_ipos", dut.ipos, 7'd0);

        // Header split into consecutive meta values.
        send_ctrl(`DTYPE_HEADER_START);
        send_header(32'h0002_0001);
        send_header(32'h0004_0003);
        drain("hdr_drain");
        check("image_type_literal", image_type, 16'h0003);
        check("image_type_model", image_type, m_image_type);
        check("meta_hold_value", meta_datao, 16'h0004);
        check("meta_hold_idx", meta_idx, 8'd3);

        // Residual discard: 2 leftover bits of one word never surface.
        send_ctrl(`DTYPE_FRAME_START);
        drain("resid_pre_drain");
        wone.push_back(32'hFFFF_FFFF);
        exp_pixels(wone, PIX_B, n);
        check("resid_model_count", n, 1);
        exp_ctrl(`DTYPE_FRAME_END);
        send_word(PIX_B, 32'hFFFF_FFFF, wt);
        dvi = 1'b1; dtypei = `DTYPE_FRAME_END; datai = '0;
        @(negedge clk);
        check("resid_holdoff", rdyo, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("resid_pixel", {r, g, b}, 30'h3FFF_FFFF);
        check("resid_pixel_dtype", dtypeo, PIX_B);
        check("resid_rdyo", rdyo, 1'b1);
        @(posedge clk); #1;
        dvi = 1'b0;
        @(negedge clk);
        check("resid_fwd_dvo", dvo, 1'b1);
        check("resid_fwd_dtype", dtypeo, `DTYPE_FRAME_END);
        check("resid_ipos", dut.ipos, 7'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("resid_no_leftover", dvo, 1'b0);
        check("resid_queue", expq.size(), 0);
        @(posedge clk); #1;

        // 100 pixels unstalled, then with random dvi gaps.
        for (int i = 0; i < 100; i++)
            px100.push_back({10'(i * 7), 10'(1023 - i), 10'(i * 13 + 5)});
        pack_pixels(px100, wq100);
        check("long_word_count", wq100.size(), 94);
        send_ctrl(`DTYPE_FRAME_START);
        exp_pixels(wq100, PIX_A, n);
        check("long_model_count", n, 100);
        base = obs_pix.size();
        rdyo_low = 0;
        send_words(wq100, PIX_A, 1'b0);
        send_ctrl(`DTYPE_FRAME_END);
        drain("long_drain");
        check("long_rdyo_low", rdyo_low > 0, 1'b1);
        check("long_pix_count", obs_pix.size() - base, 100);

        send_ctrl(`DTYPE_FRAME_START);
        exp_pixels(wq100, PIX_A, n);
        base2 = obs_pix.size();
        send_words(wq100, PIX_A, 1'b1);
        send_ctrl(`DTYPE_FRAME_END);
        drain("stall_drain");
        check("stall_pix_count", obs_pix.size() - base2, 100);
        if (obs_pix.size() - base2 == 100)
            for (int i = 0; i < 100; i++) check("stall_pixel", obs_pix[base2 + i], px100[i]);

        // Reset during the second half of a header word.
        send_ctrl(`DTYPE_HEADER_START);
        exp_meta(16'h5555);
        exp_meta(16'hAAAA);
        send_word(`DTYPE_HEADER, 32'hAAAA_5555, wt);
        apply_reset("rst_hdr");

        // Reset in the middle of a pixel burst.
        send_ctrl(`DTYPE_FRAME_START);
        exp_pixels(wq100, PIX_A, n);
        for (int i = 0; i < 5; i++) send_word(PIX_A, wq100[i], wt);
        dvi = 1'b1; dtypei = PIX_A; datai = wq100[5];
        apply_reset("rst_pix");

        // Fresh frame after reset.
        send_ctrl(`DTYPE_FRAME_START);
        exp_pixels(wq16, PIX_A, n);
        base = obs_pix.size();
        send_words(wq16, PIX_A, 1'b0);
        send_ctrl(`DTYPE_FRAME_END);
        drain("post_reset_drain");
        check("post_reset_count", obs_pix.size() - base, 16);
        if (obs_pix.size() - base == 16)
            for (int i = 0; i < 16; i++) check("post_reset_pixel", obs_pix[base + i], px16[i]);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
